// File: rtl/change_return_unit.sv
// change_return_unit: returns the committed balance as one-hot coin pulses, largest coin first.
// Define CHANGE_RETURN_TIMEOUT_EN to add the inactivity timeout return; otherwise o_wait_time is 0.
module change_return_unit #(
    parameter int NUM_COINS   = 3,
    parameter int TOTAL_BITS  = 31,
    parameter int COIN_VAL0   = 100,
    parameter int COIN_VAL1   = 500,
    parameter int COIN_VAL2   = 1000,
    parameter int WAIT_CYCLES = 100
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_trigger_return,
    input  logic                  i_activity,
    input  logic [TOTAL_BITS-1:0] i_current_total,
    output logic [NUM_COINS-1:0]  o_return_coin,
    output logic                  o_return_busy,
    output logic                  o_return_done,
    output logic [TOTAL_BITS-1:0] o_remaining,
    output logic [31:0]           o_wait_time
);
    typedef enum logic {IDLE, DISPENSE} state_t;
    localparam logic [TOTAL_BITS-1:0] VALS [3] = '{TOTAL_BITS'(COIN_VAL0), TOTAL_BITS'(COIN_VAL1), TOTAL_BITS'(COIN_VAL2)};
    state_t                state_q, state_d;
    logic [TOTAL_BITS-1:0] rem_q, rem_d;
    logic [NUM_COINS-1:0]  coin_q, coin_d;
    logic                  busy_q, busy_d, done_q, done_d;
    logic [1:0]            sel;
    logic                  timeout;
`ifdef CHANGE_RETURN_TIMEOUT_EN
    logic [31:0] wait_q, wait_d;
    assign timeout = !i_activity && i_current_total != '0 && wait_q == 32'd1;
    // Every path other than a live countdown reloads the full timeout.
    assign wait_d = (state_q == DISPENSE || i_trigger_return || i_activity || i_current_total == '0 || wait_q <= 32'd1)
                    ? 32'(WAIT_CYCLES) : wait_q - 32'd1;
    always_ff @(posedge clk) begin
        if (!reset_n) wait_q <= 32'(WAIT_CYCLES);
        else          wait_q <= wait_d;
    end
    assign o_wait_time = wait_q;
`else
    logic unused_timer;
    assign unused_timer = i_activity | (WAIT_CYCLES == 0);
    assign timeout      = 1'b0;
    assign o_wait_time  = '0;
`endif
    always_comb begin
        sel = 2'd0;
        for (int k = 1; k < 3; k++) if (rem_q >= VALS[k]) sel = 2'(k);
    end
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        coin_d  = '0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (i_trigger_return || timeout) begin
                state_d = DISPENSE;
                rem_d   = i_current_total;
                busy_d  = 1'b1;
            end
        end else if (rem_q >= VALS[0]) begin
            coin_d = NUM_COINS'(1) << sel;
            rem_d  = rem_q - VALS[sel];
        end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            coin_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            coin_q  <= coin_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
    assign o_return_coin = coin_q;
    assign o_return_busy = busy_q;
    assign o_return_done = done_q;
    assign o_remaining   = rem_q;
endmodule

// File: tb/tb_change_return_unit.sv
// tb_change_return_unit: random and directed returns checked by a coin/done scoreboard.
// Expected coin streams come from integer division of the balance by the denominations.
module tb_change_return_unit;
`ifdef CHANGE_RETURN_TIMEOUT_EN
    localparam longint EXP_WAIT = 100;
`else
    localparam longint EXP_WAIT = 0;
`endif
    typedef struct packed {
        logic [2:0]  coin;
        logic        done;
        logic [30:0] rem;
    } exp_t;
    logic        clk = 0, reset_n = 0, trig = 0, act = 0;
    logic [30:0] total = 0;
    logic [2:0]  o_return_coin;
    logic        o_return_busy, o_return_done;
    logic [30:0] o_remaining;
    logic [31:0] o_wait_time;
    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0, passes = 0;

    change_return_unit dut (
        .clk(clk), .reset_n(reset_n), .i_trigger_return(trig), .i_activity(act),
        .i_current_total(total), .o_return_coin(o_return_coin), .o_return_busy(o_return_busy),
        .o_return_done(o_return_done), .o_remaining(o_remaining), .o_wait_time(o_wait_time)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint got, input longint want);
        checks++;
        if (got == want) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, got, want);
    endtask

    task automatic push_expected(input logic [30:0] tot, output int nc);
        int     vals[3] = '{100, 500, 1000};
        longint r;
        longint cnt;
        exp_t   e;
        r  = tot;
        nc = 0;
        for (int k = 2; k >= 0; k--) begin
            cnt = r / vals[k];
            for (longint j = 0; j < cnt; j++) begin
                r      = r - vals[k];
                e.coin = 3'(1 << k);
                e.done = 1'b0;
                e.rem  = 31'(r);
                exp_q.push_back(e);
                nc++;
            end
        end
        e.coin = 3'd0;
        e.done = 1'b1;
        e.rem  = 31'(r);
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (reset_n && (o_return_coin != 0 || o_return_done)) begin
            if (exp_q.size() == 0) check("unexpected_output", {o_return_done, o_return_coin}, 0);
            else begin
                mon_e = exp_q.pop_front();
                check("coin", o_return_coin, mon_e.coin);
                check("done", o_return_done, mon_e.done);
                check("remaining", o_remaining, mon_e.rem);
            end
        end
    end

    task automatic run_return(input logic [30:0] tot, input logic with_act);
        int n, nc, busy_n;
        @(negedge clk);
        total = tot; trig = 1; act = with_act;
        push_expected(tot, nc);
        @(posedge clk); #1;
        trig = 0; act = 0;
        check("busy_on_entry", o_return_busy, 1);
        n = 0; busy_n = 1;
        while (!o_return_done && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (o_return_busy) busy_n++;
        end
        check("done_latency", n, nc + 1);
        check("busy_cycles", busy_n, nc + 1);
        check("coin_on_done", o_return_coin, 0);
        @(negedge clk);
        total = 0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_coin"}, o_return_coin, 0);
        check({tag, "_busy"}, o_return_busy, 0);
        check({tag, "_done"}, o_return_done, 0);
        check({tag, "_remaining"}, o_remaining, 0);
        check({tag, "_wait"}, o_wait_time, EXP_WAIT);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nc, k;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        reset_n = 1;
        run_return(31'd1700, 1'b0);
        run_return(31'd650, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("residue_hold", o_remaining, 50);
        check("idle_busy", o_return_busy, 0);
        run_return(31'd0, 1'b0);
        repeat (300) @(posedge clk);
        #1;
        check("zero_idle_busy", o_return_busy, 0);
        check("zero_idle_wait", o_wait_time, EXP_WAIT);
`ifdef CHANGE_RETURN_TIMEOUT_EN
        @(negedge clk);
        total = 500;
        push_expected(31'd500, nc);
        k = 0;
        while (!o_return_busy && k < 200) begin
            @(posedge clk); #1;
            k++;
            if (k == 60) check("wait_count", o_wait_time, 40);
        end
        check("timeout_edge", k, 100);
        check("timeout_wait_reload", o_wait_time, 100);
        k = 0;
        while (!o_return_done && k < 20) begin @(posedge clk); #1; k++; end
        check("timeout_done", o_return_done, 1);
        @(negedge clk);
        total = 0;
        @(negedge clk);
        total = 500;
        push_expected(31'd500, nc);
        k = 0;
        while (o_wait_time != 40 && k < 200) begin @(posedge clk); #1; k++; end
        check("reach_40", o_wait_time, 40);
        act = 1;
        @(posedge clk); #1;
        act = 0;
        check("activity_reload", o_wait_time, 100);
        k = 0;
        while (!o_return_busy && k < 200) begin @(posedge clk); #1; k++; end
        check("post_activity_timeout", k, 100);
        k = 0;
        while (!o_return_done && k < 20) begin @(posedge clk); #1; k++; end
        check("activity_timeout_done", o_return_done, 1);
        @(negedge clk);
        total = 0;
`else
        @(negedge clk);
        total = 500;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            act = (i % 7 == 0);
        end
        act = 0;
        @(posedge clk); #1;
        check("no_timeout_busy", o_return_busy, 0);
        check("no_timeout_wait", o_wait_time, 0);
        @(negedge clk);
        total = 0;
`endif
        run_return(31'd1234, 1'b1);
        @(negedge clk);
        total = 1700; trig = 1;
        push_expected(31'd1700, nc);
        @(posedge clk); #1;
        trig = 0;
        @(posedge clk); #1;
        check("first_coin_before_reset", o_return_coin, 4);
        @(negedge clk); #1;
        exp_q.delete();
        reset_n = 0;
        @(posedge clk); #1;
        check_reset_state("mid_reset");
        @(negedge clk);
        reset_n = 1;
        total = 0;
        repeat (20) @(posedge clk);
        #1;
        check("after_reset_busy", o_return_busy, 0);
        repeat (20) begin
            run_return(31'($urandom_range(0, 4000)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 5)) @(posedge clk);
        end
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
